// File: rtl/store_pkg.sv
// Shared size encodings, FSM states and lane selection for the store narrowing path.
// Optional byte-enable variant is selected with STORE_BYTE_ENABLE_EN.
package store_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, FIN} state_t;

  typedef struct packed {
    logic [1:0] lane;
    logic [3:0] be;
  } lane_sel_t;

  // lane is the lowest byte lane touched; big-endian mirrors the lane order.
  function automatic lane_sel_t lane_select(input logic [1:0] size, input logic [1:0] addr_lo,
                                            input logic big_endian);
    lane_sel_t sel;
    sel.lane = 2'd0;
    sel.be   = 4'b0000;
    case (size)
      SZ_BYTE: begin
        sel.lane = big_endian ? ~addr_lo : addr_lo;
        sel.be   = 4'b0001 << sel.lane;
      end
      SZ_HALF: begin
        sel.lane = {addr_lo[1] ^ big_endian, 1'b0};
        sel.be   = 4'b0011 << sel.lane;
      end
      SZ_WORD: sel.be = 4'b1111;
      default: ;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: drops the store data into the selected byte lanes of old_word.
module store_lane_merge
  import store_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  output logic [31:0] merged,
  output logic [3:0]  be
);

  lane_sel_t  sel;
  logic [1:0] src;

  // Active lane i takes data byte (i - lane), so the low data byte lands in the lowest lane.
  always_comb begin
    sel    = lane_select(size, addr_lo, BIG_ENDIAN);
    be     = sel.be;
    merged = old_word;
    src    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      src = 2'(i) - sel.lane;
      if (sel.be[i]) merged[i*8 +: 8] = wdata[{src, 3'b000} +: 8];
    end
  end

endmodule

// File: rtl/store_narrow_unit.sv
// Narrows a register value to byte/half/word and stores it to word-only memory.
// Default: read-modify-write for sub-word stores; STORE_BYTE_ENABLE_EN adds mem_be and skips the read.
module store_narrow_unit
  import store_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata,
`ifdef STORE_BYTE_ENABLE_EN
  output logic [3:0]        mem_be,
`endif
  output logic              done,
  output logic              misalign_err
);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          size_q;
  logic [31:0]         wdata_q;
  logic                err_q;
  logic [31:0]         old_word;
  logic [31:0]         merged;
  logic [3:0]          be;
  logic                misaligned;
  logic                accept;

  assign accept     = req_valid && (state == IDLE);
  assign misaligned = (req_size == 2'b11) ||
                      (req_size == SZ_HALF && req_addr[0]) ||
                      (req_size == SZ_WORD && req_addr[1:0] != 2'b00);

`ifdef STORE_BYTE_ENABLE_EN
  // No read phase: feeding the replicated word as the background makes merged fully replicated.
  assign old_word = replicate(size_q, wdata_q);
`else
  logic [31:0] rdata_q;
  assign old_word = rdata_q;
`endif

  store_lane_merge #(.BIG_ENDIAN(BIG_ENDIAN)) u_merge (
    .old_word (old_word),
    .wdata    (wdata_q),
    .size     (size_q),
    .addr_lo  (addr_q[1:0]),
    .merged   (merged),
    .be       (be)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
`ifndef STORE_BYTE_ENABLE_EN
      rdata_q <= '0;
`endif
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q  <= req_addr;
        size_q  <= req_size;
        wdata_q <= req_wdata;
        err_q   <= misaligned;
      end
`ifndef STORE_BYTE_ENABLE_EN
      if (state == WAIT) rdata_q <= mem_rdata;
`endif
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (misaligned)               state_n = FIN;
          else if (req_size == SZ_WORD) state_n = WRITE;
`ifdef STORE_BYTE_ENABLE_EN
          else                          state_n = WRITE;
`else
          else                          state_n = READ;
`endif
        end
      end
      READ:    state_n = WAIT;
      WAIT:    state_n = WRITE;
      WRITE:   state_n = FIN;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    req_ready    = (state == IDLE);
`ifdef STORE_BYTE_ENABLE_EN
    mem_rd_en    = 1'b0;
    mem_be       = (state == WRITE) ? be : 4'b0000;
`else
    mem_rd_en    = (state == READ);
`endif
    mem_wr_en    = (state == WRITE);
    mem_wdata    = (state == WRITE) ? merged : 32'd0;
    mem_addr     = (state == READ || state == WAIT || state == WRITE) ?
                   {addr_q[ADDR_W-1:2], 2'b00} : '0;
    done         = (state == FIN);
    misalign_err = (state == FIN) && err_q;
  end

endmodule
